// File: rtl/symbol_mapper_if.sv
// symbol_mapper_if: bit-group input and mapped-level output
// handshakes grouped as one bundle for the mapper and its driver.
interface symbol_mapper_if #(
  parameter int N = 16
) ();
  logic [7:0]   in_bits;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] xI1;
  logic [N-1:0] xQ1;
  logic [N-1:0] xI2;
  logic [N-1:0] xQ2;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [15:0]  sym_cnt;

  modport master (
    output in_bits, in_valid, out_ready,
    input  in_ready, xI1, xQ1, xI2, xQ2,
    input  out_valid, out_last, sym_cnt
  );

  modport slave (
    input  in_bits, in_valid, out_ready,
    output in_ready, xI1, xQ1, xI2, xQ2,
    output out_valid, out_last, sym_cnt
  );
endinterface

// File: rtl/symbol_mapper.sv
// symbol_mapper: 4-PAM mapper with 2-entry output FIFO and frame count.
// GRAY_MAP_EN selects Gray-decoded fields instead of natural binary.
module symbol_mapper #(
  parameter int N         = 16,
  parameter int Q         = 8,
  parameter int FRAME_LEN = 64
) (
  input logic           clk,
  input logic           rst,
  symbol_mapper_if.slave bus
);

  localparam logic [N-1:0] L_M3 = N'(-(3 << Q));
  localparam logic [N-1:0] L_M1 = N'(-(1 << Q));
  localparam logic [N-1:0] L_P1 = N'(1 << Q);
  localparam logic [N-1:0] L_P3 = N'(3 << Q);
  localparam logic [15:0]  LAST = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [4*N-1:0] mem [2];
  logic [4*N-1:0] mapped;
  logic [4*N-1:0] head;
  logic           wr_ptr;
  logic           rd_ptr;
  logic           in_rdy;
  logic [15:0]    cnt;
  logic           push;
  logic           pop;
  logic           valid;

  function automatic logic [N-1:0] map2(input logic [1:0] f);
    logic [1:0] idx;
`ifdef GRAY_MAP_EN
    idx = {f[1], f[1] ^ f[0]};
`else
    idx = f;
`endif
    case (idx)
      2'd0:    map2 = L_M3;
      2'd1:    map2 = L_M1;
      2'd2:    map2 = L_P1;
      default: map2 = L_P3;
    endcase
  endfunction

  assign mapped = {map2(bus.in_bits[7:6]), map2(bus.in_bits[5:4]),
                   map2(bus.in_bits[3:2]), map2(bus.in_bits[1:0])};
  assign valid  = (state != EMPTY);
  assign push   = bus.in_valid & in_rdy;
  assign pop    = valid & bus.out_ready;
  assign head   = mem[rd_ptr];

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = valid;
  assign bus.sym_cnt   = cnt;
  assign bus.out_last  = valid && (cnt == LAST);
  assign bus.xI1 = valid ? head[4*N-1:3*N] : '0;
  assign bus.xQ1 = valid ? head[3*N-1:2*N] : '0;
  assign bus.xI2 = valid ? head[2*N-1:N]   : '0;
  assign bus.xQ2 = valid ? head[N-1:0]     : '0;

  // occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // occupancy next state from push/pop
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:  if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // pointers, registered ready and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      in_rdy <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        cnt    <= (cnt == LAST) ? '0 : cnt + 16'd1;
      end
      in_rdy <= (state_nxt != FULL);
    end
  end

  // FIFO storage of mapped levels
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mapped;
  end

endmodule

// File: tb/tb_symbol_mapper.sv
// tb_symbol_mapper: directed and random traffic against a queue-based
// reference model of the mapper's ordering, levels and frame count.
module tb_symbol_mapper;
  localparam int N  = 16;
  localparam int Q  = 8;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  symbol_mapper_if #(.N(N)) bus ();

  symbol_mapper #(.N(N), .Q(Q), .FRAME_LEN(FL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         cnt = 0;
  bit         m_rdy = 1'b0;
  int         nlast;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lvl(input logic [7:0] b, input int k);
    int gt[4] = '{0, 1, 3, 2};
    int f;
    int idx;
    int v;
    f = int'(b[7-2*k -: 2]);
`ifdef GRAY_MAP_EN
    idx = gt[f];
`else
    idx = f;
`endif
    v = (2 * idx - 3) * (1 << Q);
    return 16'(v);
  endfunction

  task automatic check_all();
    logic [15:0] xs[4];
    logic [15:0] ex;
    bit          has;
    xs[0] = bus.xI1;
    xs[1] = bus.xQ1;
    xs[2] = bus.xI2;
    xs[3] = bus.xQ2;
    has = (q.size() != 0);
    chk("out_valid", 32'(bus.out_valid), 32'(has));
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("sym_cnt", 32'(bus.sym_cnt), 32'(cnt));
    chk("out_last", 32'(bus.out_last), 32'(has && cnt == FL - 1));
    for (int k = 0; k < 4; k++) begin
      ex = has ? lvl(q[0], k) : 16'h0;
      chk($sformatf("x%0d", k), 32'(xs[k]), 32'(ex));
    end
  endtask

  task automatic tick(input bit r, input bit v, input logic [7:0] b,
                      input bit ordy);
    bit acc;
    bit pop;
    rst           = r;
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.out_ready = ordy;
    acc = v && m_rdy;
    pop = (q.size() != 0) && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt   = 0;
      m_rdy = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % FL;
      end
      if (acc) q.push_back(b);
      m_rdy = (q.size() < 2);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] pat;
`ifdef GRAY_MAP_EN
    pat = 8'b00011110;
`else
    pat = 8'b00011011;
`endif
    bus.in_bits   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'hA5, 1);
    tick(0, 0, 8'h00, 1);

    tick(0, 1, pat, 1);
    chk("const_xI1", 32'(bus.xI1), 32'h0000FD00);
    chk("const_xQ1", 32'(bus.xQ1), 32'h0000FF00);
    chk("const_xI2", 32'(bus.xI2), 32'h00000100);
    chk("const_xQ2", 32'(bus.xQ2), 32'h00000300);
    tick(0, 0, 8'h00, 1);

    tick(0, 1, 8'h1B, 0);
    tick(0, 1, 8'hE4, 0);
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    tick(0, 1, 8'h72, 0);
    tick(0, 1, 8'h72, 0);
    tick(0, 1, 8'h72, 1);
    tick(0, 1, 8'h72, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 1);

    tick(1, 0, 8'h00, 1);
    tick(0, 0, 8'h00, 1);
    nlast = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, i < 9, 8'($urandom), 1);
      if (bus.out_last === 1'b1) nlast++;
    end
    chk("last_count", 32'(nlast), 32'd2);

    tick(1, 0, 8'h00, 1);
    tick(0, 0, 8'h00, 1);
    tick(0, 1, 8'h11, 1);
    tick(0, 1, 8'h22, 1);
    tick(0, 0, 8'h00, 1);
    tick(0, 1, 8'h33, 0);
    tick(0, 1, 8'h44, 0);
    chk("full_cnt", 32'(bus.sym_cnt), 32'd2);
    tick(1, 1, 8'h55, 1);
    tick(0, 1, 8'h66, 1);
    tick(0, 0, 8'h00, 0);
    chk("post_rst_cnt", 32'(bus.sym_cnt), 32'd0);
    tick(0, 0, 8'h00, 1);

    tick(0, 1, 8'h9C, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 8'($urandom), 1);
    tick(0, 0, 8'h00, 1);

    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), $urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
